// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes and the reservation-station entry layout.
// snoop_src resolves one source operand against the two result buses.
package alu_pkg;

  localparam int DATA_LEN      = 32;
  localparam int ALU_OP_WIDTH  = 4;
  localparam int RRF_TAG_WIDTH = 6;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd9;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]  op;
    logic [DATA_LEN-1:0]      src1;
    logic                     src1_vld;
    logic [DATA_LEN-1:0]      src2;
    logic                     src2_vld;
    logic [RRF_TAG_WIDTH-1:0] rrftag;
    logic                     wrrrf;
  } rs_entry_t;

  typedef struct packed {
    logic                vld;
    logic [DATA_LEN-1:0] val;
  } rs_src_t;

  // A pending source holds its tag in the low bits; CDB0 takes precedence on a double match.
  function automatic rs_src_t snoop_src(
    input logic [DATA_LEN-1:0]      val,
    input logic                     vld,
    input logic                     c0_valid,
    input logic [RRF_TAG_WIDTH-1:0] c0_tag,
    input logic [DATA_LEN-1:0]      c0_data,
    input logic                     c1_valid,
    input logic [RRF_TAG_WIDTH-1:0] c1_tag,
    input logic [DATA_LEN-1:0]      c1_data
  );
    rs_src_t r;
    r.vld = vld;
    r.val = val;
    if (!vld) begin
      if (c0_valid && (val[RRF_TAG_WIDTH-1:0] == c0_tag)) begin
        r.vld = 1'b1;
        r.val = c0_data;
      end else if (c1_valid && (val[RRF_TAG_WIDTH-1:0] == c1_tag)) begin
        r.vld = 1'b1;
        r.val = c1_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station: age[i][j]=1 means entry j is older than entry i.
// Grants the single ready entry that has no older ready entry.
module rs_age_matrix #(
  parameter int RS_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kill,
  input  logic [RS_ENTRIES-1:0] valid,
  input  logic [RS_ENTRIES-1:0] ready,
  input  logic [RS_ENTRIES-1:0] alloc,
  input  logic [RS_ENTRIES-1:0] free,
  output logic [RS_ENTRIES-1:0] grant
);

  logic [RS_ENTRIES-1:0] age [RS_ENTRIES];

  // A new row records every surviving entry as older; freeing clears that entry's column.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      for (int r = 0; r < RS_ENTRIES; r++) age[r] <= '0;
    end else begin
      for (int r = 0; r < RS_ENTRIES; r++) begin
        for (int c = 0; c < RS_ENTRIES; c++) begin
          if (alloc[r]) age[r][c] <= valid[c] & ~free[c] & ~alloc[c];
          else if (free[c]) age[r][c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < RS_ENTRIES; i++) grant[i] = ready[i] & ~|(age[i] & ready);
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, snoops CDB0/CDB1 for operands,
// and issues the oldest ready op to the single-cycle ALU through registered outputs.
module alu_rs_scheduler
  import alu_pkg::*;
#(
  parameter int RS_ENTRIES = 8,
  parameter int CNT_W      = $clog2(RS_ENTRIES) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     kill_i,
  input  logic                     dispatch_valid_i,
  output logic                     dispatch_ready_o,
  input  logic [ALU_OP_WIDTH-1:0]  dispatch_op_i,
  input  logic [DATA_LEN-1:0]      dispatch_src1_i,
  input  logic                     dispatch_src1_vld_i,
  input  logic [DATA_LEN-1:0]      dispatch_src2_i,
  input  logic                     dispatch_src2_vld_i,
  input  logic [RRF_TAG_WIDTH-1:0] dispatch_rrftag_i,
  input  logic                     dispatch_wrrrf_i,
  input  logic                     cdb0_valid_i,
  input  logic [RRF_TAG_WIDTH-1:0] cdb0_tag_i,
  input  logic [DATA_LEN-1:0]      cdb0_data_i,
  input  logic                     cdb1_valid_i,
  input  logic [RRF_TAG_WIDTH-1:0] cdb1_tag_i,
  input  logic [DATA_LEN-1:0]      cdb1_data_i,
  output logic                     issue_o,
  output logic [ALU_OP_WIDTH-1:0]  alu_op_o,
  output logic [DATA_LEN-1:0]      src1_o,
  output logic [DATA_LEN-1:0]      src2_o,
  output logic                     if_write_rrf_o,
  output logic [RRF_TAG_WIDTH-1:0] issue_rrftag_o,
  output logic [CNT_W-1:0]         free_count_o
);

  rs_entry_t             ent     [RS_ENTRIES];
  rs_entry_t             ent_nxt [RS_ENTRIES];
  rs_entry_t             disp_ent;
  rs_entry_t             sel;
  logic [RS_ENTRIES-1:0] valid;
  logic [RS_ENTRIES-1:0] ready;
  logic [RS_ENTRIES-1:0] grant;
  logic [RS_ENTRIES-1:0] alloc_vec;
  logic                  accept;
  logic                  issue_now;

  function automatic rs_src_t wake(input logic [DATA_LEN-1:0] val, input logic vld);
    return snoop_src(val, vld, cdb0_valid_i, cdb0_tag_i, cdb0_data_i,
                     cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
  endfunction

  // Handshake: a dispatch is taken on a cycle where dispatch_valid_i & dispatch_ready_o
  // and kill_i is low; ready depends only on current occupancy, never on a same-cycle issue.
  assign dispatch_ready_o = ~reset & ~&valid;
  assign accept           = dispatch_valid_i & dispatch_ready_o & ~kill_i;
  assign issue_now        = |grant;

  always_comb begin
    alloc_vec = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_vec    = '0;
        alloc_vec[i] = 1'b1;
      end
    end
    if (!accept) alloc_vec = '0;
  end

  always_comb begin
    rs_src_t s1;
    rs_src_t s2;
    s1 = wake(dispatch_src1_i, dispatch_src1_vld_i);
    s2 = wake(dispatch_src2_i, dispatch_src2_vld_i);
    disp_ent.op       = dispatch_op_i;
    disp_ent.src1     = s1.val;
    disp_ent.src1_vld = s1.vld;
    disp_ent.src2     = s2.val;
    disp_ent.src2_vld = s2.vld;
    disp_ent.rrftag   = dispatch_rrftag_i;
    disp_ent.wrrrf    = dispatch_wrrrf_i;
  end

  always_comb begin
    rs_src_t w1;
    rs_src_t w2;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      w1 = wake(ent[i].src1, ent[i].src1_vld);
      w2 = wake(ent[i].src2, ent[i].src2_vld);
      ent_nxt[i]          = ent[i];
      ent_nxt[i].src1     = w1.val;
      ent_nxt[i].src1_vld = w1.vld;
      ent_nxt[i].src2     = w2.val;
      ent_nxt[i].src2_vld = w2.vld;
      if (alloc_vec[i]) ent_nxt[i] = disp_ent;
    end
  end

  // Readiness comes from registered operand state, so a wakeup never issues in its own cycle.
  always_comb begin
    ready = '0;
    sel   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      ready[i] = valid[i] & ent[i].src1_vld & ent[i].src2_vld;
      if (grant[i]) sel = ent[i];
    end
  end

  rs_age_matrix #(.RS_ENTRIES(RS_ENTRIES)) u_age (
    .clk   (clk),
    .reset (reset),
    .kill  (kill_i),
    .valid (valid),
    .ready (ready),
    .alloc (alloc_vec),
    .free  (grant),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_ENTRIES; i++) ent[i] <= ent_nxt[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid          <= '0;
      issue_o        <= 1'b0;
      alu_op_o       <= '0;
      src1_o         <= '0;
      src2_o         <= '0;
      if_write_rrf_o <= 1'b0;
      issue_rrftag_o <= '0;
      free_count_o   <= CNT_W'(RS_ENTRIES);
    end else if (kill_i) begin
      valid        <= '0;
      issue_o      <= 1'b0;
      free_count_o <= CNT_W'(RS_ENTRIES);
    end else begin
      valid   <= (valid & ~grant) | alloc_vec;
      issue_o <= issue_now;
      if (issue_now) begin
        alu_op_o       <= sel.op;
        src1_o         <= sel.src1;
        src2_o         <= sel.src2;
        if_write_rrf_o <= sel.wrrrf;
        issue_rrftag_o <= sel.rrftag;
      end
      free_count_o <= free_count_o - CNT_W'(accept) + CNT_W'(issue_now);
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: an age-ordered queue model checked every cycle,
// a table of dispatch/bypass vectors, directed corner sequences and random traffic.
module tb_alu_rs_scheduler;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kill_i = 1'b0;
  logic        dispatch_valid_i = 1'b0;
  logic        dispatch_ready_o;
  logic [3:0]  dispatch_op_i = '0;
  logic [31:0] dispatch_src1_i = '0;
  logic        dispatch_src1_vld_i = 1'b0;
  logic [31:0] dispatch_src2_i = '0;
  logic        dispatch_src2_vld_i = 1'b0;
  logic [5:0]  dispatch_rrftag_i = '0;
  logic        dispatch_wrrrf_i = 1'b0;
  logic        cdb0_valid_i = 1'b0;
  logic [5:0]  cdb0_tag_i = '0;
  logic [31:0] cdb0_data_i = '0;
  logic        cdb1_valid_i = 1'b0;
  logic [5:0]  cdb1_tag_i = '0;
  logic [31:0] cdb1_data_i = '0;
  logic        issue_o;
  logic [3:0]  alu_op_o;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic        if_write_rrf_o;
  logic [5:0]  issue_rrftag_o;
  logic [3:0]  free_count_o;

  alu_rs_scheduler dut (
    .clk(clk), .reset(reset), .kill_i(kill_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_op_i(dispatch_op_i),
    .dispatch_src1_i(dispatch_src1_i), .dispatch_src1_vld_i(dispatch_src1_vld_i),
    .dispatch_src2_i(dispatch_src2_i), .dispatch_src2_vld_i(dispatch_src2_vld_i),
    .dispatch_rrftag_i(dispatch_rrftag_i), .dispatch_wrrrf_i(dispatch_wrrrf_i),
    .cdb0_valid_i(cdb0_valid_i), .cdb0_tag_i(cdb0_tag_i), .cdb0_data_i(cdb0_data_i),
    .cdb1_valid_i(cdb1_valid_i), .cdb1_tag_i(cdb1_tag_i), .cdb1_data_i(cdb1_data_i),
    .issue_o(issue_o), .alu_op_o(alu_op_o), .src1_o(src1_o), .src2_o(src2_o),
    .if_write_rrf_o(if_write_rrf_o), .issue_rrftag_o(issue_rrftag_o),
    .free_count_o(free_count_o)
  );

  // Clock/reset: 10-time-unit period; reset is driven from the test sequence.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries kept oldest-first in a queue.
  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic        v1;
    logic [31:0] s2;
    logic        v2;
    logic [5:0]  tag;
    logic        wr;
  } m_ent_t;

  m_ent_t      mq[$];
  logic [5:0]  exp_q[$];
  logic        e_issue = 0;
  logic [3:0]  e_op = 0;
  logic [31:0] e_s1 = 0;
  logic [31:0] e_s2 = 0;
  logic        e_wr = 0;
  logic [5:0]  e_tag = 0;
  logic [3:0]  e_free = 8;
  logic        acc_last = 0;

  function automatic logic [32:0] m_wake(input logic [31:0] v, input logic vld);
    if (vld) return {1'b1, v};
    if (cdb0_valid_i && v[5:0] == cdb0_tag_i) return {1'b1, cdb0_data_i};
    if (cdb1_valid_i && v[5:0] == cdb1_tag_i) return {1'b1, cdb1_data_i};
    return {1'b0, v};
  endfunction

  task automatic model_step();
    int          sel;
    logic        rdy;
    logic [32:0] w;
    m_ent_t      e;
    rdy = !reset && (mq.size() < 8);
    check("dispatch_ready", dispatch_ready_o, rdy);
    acc_last = 0;
    if (reset) begin
      mq.delete();
      e_issue = 0; e_op = 0; e_s1 = 0; e_s2 = 0; e_wr = 0; e_tag = 0;
    end else if (kill_i) begin
      mq.delete();
      e_issue = 0;
    end else begin
      sel = -1;
      foreach (mq[k]) if (sel < 0 && mq[k].v1 && mq[k].v2) sel = k;
      e_issue = (sel >= 0);
      if (sel >= 0) begin
        e_op = mq[sel].op; e_s1 = mq[sel].s1; e_s2 = mq[sel].s2;
        e_wr = mq[sel].wr; e_tag = mq[sel].tag;
        mq.delete(sel);
      end
      foreach (mq[k]) begin
        w = m_wake(mq[k].s1, mq[k].v1); mq[k].v1 = w[32]; mq[k].s1 = w[31:0];
        w = m_wake(mq[k].s2, mq[k].v2); mq[k].v2 = w[32]; mq[k].s2 = w[31:0];
      end
      if (dispatch_valid_i && rdy) begin
        e.op = dispatch_op_i; e.tag = dispatch_rrftag_i; e.wr = dispatch_wrrrf_i;
        w = m_wake(dispatch_src1_i, dispatch_src1_vld_i); e.v1 = w[32]; e.s1 = w[31:0];
        w = m_wake(dispatch_src2_i, dispatch_src2_vld_i); e.v2 = w[32]; e.s2 = w[31:0];
        mq.push_back(e);
        acc_last = 1;
      end
    end
    e_free = 4'(8 - mq.size());
  endtask

  // One clock: inputs already driven; model advances, then registered outputs compared.
  task automatic cycle();
    #2;
    model_step();
    @(posedge clk);
    #1;
    check("issue_o", issue_o, e_issue);
    check("free_count_o", free_count_o, e_free);
    check("alu_op_o", alu_op_o, e_op);
    check("src1_o", src1_o, e_s1);
    check("src2_o", src2_o, e_s2);
    check("if_write_rrf_o", if_write_rrf_o, e_wr);
    check("issue_rrftag_o", issue_rrftag_o, e_tag);
  endtask

  // Driver tasks
  task automatic set_idle();
    dispatch_valid_i = 0; kill_i = 0;
    cdb0_valid_i = 0; cdb1_valid_i = 0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] s1, input logic v1,
                      input logic [31:0] s2, input logic v2, input logic [5:0] tag);
    dispatch_valid_i = 1; dispatch_op_i = op;
    dispatch_src1_i = s1; dispatch_src1_vld_i = v1;
    dispatch_src2_i = s2; dispatch_src2_vld_i = v2;
    dispatch_rrftag_i = tag; dispatch_wrrrf_i = 1;
  endtask

  task automatic kill_cycle();
    set_idle(); kill_i = 1; cycle(); kill_i = 0;
  endtask

  typedef struct {
    logic [31:0] s1; logic v1; logic [31:0] s2; logic v2;
    logic c0v; logic [5:0] c0t; logic [31:0] c0d;
    logic c1v; logic [5:0] c1t; logic [31:0] c1d;
    logic e_iss; logic [31:0] e_s1; logic [31:0] e_s2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int first;
    int acc_at;

    vecs[0] = '{32'h11, 1, 32'h22, 1, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 1, 32'h11, 32'h22};
    vecs[1] = '{32'hFFFF_FF05, 0, 32'h33, 1, 1, 6'h05, 32'hAA, 0, 6'h00, 32'h0, 1, 32'hAA, 32'h33};
    vecs[2] = '{32'h44, 1, 32'h07, 0, 1, 6'h07, 32'h1, 1, 6'h07, 32'h2, 1, 32'h44, 32'h1};
    vecs[3] = '{32'h08, 0, 32'h09, 0, 1, 6'h08, 32'hC0, 1, 6'h09, 32'hC1, 1, 32'hC0, 32'hC1};
    vecs[4] = '{32'h0A, 0, 32'h55, 1, 1, 6'h0B, 32'hBB, 0, 6'h00, 32'h0, 0, 32'h0, 32'h0};
    vecs[5] = '{32'hABCD_00FF, 0, 32'h66, 1, 0, 6'h00, 32'h0, 1, 6'h3F, 32'h5, 1, 32'h5, 32'h66};
    vecs[6] = '{32'h77, 1, 32'h04, 0, 0, 6'h04, 32'h9, 0, 6'h04, 32'h9, 0, 32'h0, 32'h0};

    // Reset
    reset = 1; set_idle();
    cycle(); cycle();
    check("reset_issue", issue_o, 0);
    check("reset_free", free_count_o, 8);
    reset = 0;

    // 1: single ready dispatch issues two cycles later
    disp(ALU_OP_ADD, 32'd5, 1, 32'd7, 1, 6'd1);
    cycle(); set_idle();
    check("t1_no_early_issue", issue_o, 0);
    check("t1_free_mid", free_count_o, 7);
    cycle();
    check("t1_issue", issue_o, 1);
    check("t1_op", alu_op_o, ALU_OP_ADD);
    check("t1_src1", src1_o, 5);
    check("t1_src2", src2_o, 7);
    check("t1_free_back", free_count_o, 8);
    cycle();
    check("t1_single_issue", issue_o, 0);

    // 2: pending src2 woken by CDB1
    disp(ALU_OP_SUB, 32'd3, 1, 32'h12, 0, 6'd2);
    cycle(); set_idle();
    for (int i = 0; i < 3; i++) begin cycle(); check("t2_wait", issue_o, 0); end
    cdb1_valid_i = 1; cdb1_tag_i = 6'h12; cdb1_data_i = 32'h100;
    cycle(); set_idle();
    check("t2_no_same_cycle", issue_o, 0);
    cycle();
    check("t2_issue", issue_o, 1);
    check("t2_src2", src2_o, 32'h100);
    cycle();

    // 3: same-cycle bypass at dispatch
    disp(ALU_OP_XOR, 32'd3, 0, 32'd1, 1, 6'd3);
    cdb0_valid_i = 1; cdb0_tag_i = 6'd3; cdb0_data_i = 32'd9;
    cycle(); set_idle();
    cycle();
    check("t3_issue", issue_o, 1);
    check("t3_src1", src1_o, 9);
    cycle();

    // Table: dispatch together with CDB traffic, observe two cycles later
    foreach (vecs[k]) begin
      set_idle();
      disp(4'(k), vecs[k].s1, vecs[k].v1, vecs[k].s2, vecs[k].v2, 6'(k + 16));
      cdb0_valid_i = vecs[k].c0v; cdb0_tag_i = vecs[k].c0t; cdb0_data_i = vecs[k].c0d;
      cdb1_valid_i = vecs[k].c1v; cdb1_tag_i = vecs[k].c1t; cdb1_data_i = vecs[k].c1d;
      cycle(); set_idle(); cycle();
      check("tbl_issue", issue_o, vecs[k].e_iss);
      if (vecs[k].e_iss) begin
        check("tbl_src1", src1_o, vecs[k].e_s1);
        check("tbl_src2", src2_o, vecs[k].e_s2);
      end
      kill_cycle();
    end

    // 4: fill, full back-pressure, older of two simultaneous wakeups issues first
    set_idle();
    for (int i = 0; i < 8; i++) begin
      disp(ALU_OP_OR, 32'(i), 1, 32'(8'h20 + i), 0, 6'(i));
      cycle();
    end
    disp(ALU_OP_OR, 32'd9, 1, 32'd9, 1, 6'd9);
    #2;
    check("t4_full_ready", dispatch_ready_o, 0);
    cycle();
    check("t4_full_count", free_count_o, 0);
    set_idle();
    cdb0_valid_i = 1; cdb0_tag_i = 6'h27; cdb0_data_i = 32'h700;
    cdb1_valid_i = 1; cdb1_tag_i = 6'h22; cdb1_data_i = 32'h200;
    cycle(); set_idle();
    check("t4_no_issue_yet", issue_o, 0);
    cycle();
    check("t4_first_tag", issue_rrftag_o, 2);
    check("t4_first_src2", src2_o, 32'h200);
    cycle();
    check("t4_second_tag", issue_rrftag_o, 7);
    check("t4_second_src2", src2_o, 32'h700);
    kill_cycle();

    // 5: eight entries woken together drain in dispatch order; held dispatch enters after first issue
    set_idle();
    for (int i = 0; i < 8; i++) begin
      disp(ALU_OP_AND, 32'(i), 1, 32'h30, 0, 6'(i));
      exp_q.push_back(6'(i));
      cycle();
    end
    disp(ALU_OP_AND, 32'd100, 1, 32'd200, 1, 6'd8);
    exp_q.push_back(6'd8);
    cdb0_valid_i = 1; cdb0_tag_i = 6'h30; cdb0_data_i = 32'h55;
    cycle();
    cdb0_valid_i = 0;
    first = -1; acc_at = -1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle();
      if (acc_last) begin acc_at = c; dispatch_valid_i = 0; end
      if (first >= 0) check("t5_one_per_cycle", issue_o, 1);
      if (issue_o) begin
        check("t5_order", issue_rrftag_o, exp_q.pop_front());
        if (first < 0) first = c;
      end
    end
    check("t5_drained", exp_q.size(), 0);
    check("t5_held_accept", acc_at, first + 1);
    set_idle(); cycle();

    // 6: kill with live entries and an op selected
    for (int i = 0; i < 4; i++) begin
      disp(ALU_OP_SLT, 32'(i), 1, 32'h31, 0, 6'(i));
      cycle();
    end
    disp(ALU_OP_SLT, 32'd4, 1, 32'd4, 1, 6'd4);
    cdb0_valid_i = 1; cdb0_tag_i = 6'h31; cdb0_data_i = 32'h99;
    cycle();
    check("t6_five_valid", free_count_o, 3);
    kill_cycle();
    check("t6_kill_issue", issue_o, 0);
    check("t6_kill_free", free_count_o, 8);
    for (int i = 0; i < 4; i++) begin cycle(); check("t6_no_late_issue", issue_o, 0); end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_idle();
      reset = ($urandom_range(0, 199) == 0);
      kill_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 7)
        disp(4'($urandom_range(0, 9)), $urandom, 1'($urandom_range(0, 1)),
             $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 9) < 4) begin
        cdb0_valid_i = 1; cdb0_tag_i = 6'($urandom_range(0, 63)); cdb0_data_i = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        cdb1_valid_i = 1; cdb1_tag_i = 6'($urandom_range(0, 63)); cdb1_data_i = $urandom;
      end
      // Low tag bits drawn from a small set so wakeups actually land.
      dispatch_src1_i[5:3] = 3'b0; dispatch_src2_i[5:3] = 3'b0;
      cdb0_tag_i[5:3] = 3'b0; cdb1_tag_i[5:3] = 3'b0;
      cycle();
    end
    reset = 0;
    set_idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
